// File: rtl/zx48_pkg.sv
// Shared PS/2 definitions: prefix bytes, frame FSM states, decoded event layout
// and the frame acceptance check.
package zx48_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       extended;
    logic       released;
    logic [7:0] code;
  } ps2_event_t;

  // Odd parity over data plus parity bit, and a high stop bit.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                    input logic stop);
    return (^{data, parity}) & stop;
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Event queue for the PS/2 receiver. DEPTH=1 behaves as a single holding
// register; larger depths form a circular buffer with wrapping pointers.
module ps2_fifo
  import zx48_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic       push_i,
  input  ps2_event_t data_i,
  input  logic       pop_i,
  output ps2_event_t data_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       overflow_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  ps2_event_t    mem_q [2**PW];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          pop_ok;
  logic          push_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign overflow_o = overflow_q;
  assign data_o     = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop on a full queue frees the slot the simultaneous push needs.
  assign pop_ok  = ce_i & pop_i & ~empty_o;
  assign push_ok = ce_i & push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (ce_i && push_i && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronise, deglitch, deframe, fold E0/F0 prefixes
// into queued events. Define PS2_FIFO_EN for an 8-deep queue (default: 1 entry).
module ps2_receiver
  import zx48_pkg::*;
#(
  parameter int TIMEOUT = 700,
  parameter int FILTER  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic       valid,
  input  logic       ack,
  output logic [7:0] code,
  output logic       extended,
  output logic       released,
  output logic       error,
  output logic       overflow,
  output logic [1:0] state_dbg
);

`ifdef PS2_FIFO_EN
  localparam int QDEPTH = 8;
`else
  localparam int QDEPTH = 1;
`endif

  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          clk_filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          fall_q;
  logic          bit_q;

  // The filtered clock only moves after FILTER consecutive samples disagree with
  // it; the data bit is captured in the same tick the falling level is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
      bit_q      <= 1'b1;
    end else if (ce) begin
      clk_sync_q <= {clk_sync_q[0], ps2[1]};
      dat_sync_q <= {dat_sync_q[0], ps2[0]};
      fall_q     <= 1'b0;
      if (clk_sync_q[1] == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER - 1)) begin
        clk_filt_q <= clk_sync_q[1];
        filt_cnt_q <= '0;
        fall_q     <= ~clk_sync_q[1];
        bit_q      <= dat_sync_q[1];
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  ps2_state_e    state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] tmo_q;
  logic          ext_q;
  logic          rel_q;
  logic          push_q;
  ps2_event_t    push_ev_q;
  logic          error_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      push_q    <= 1'b0;
      push_ev_q <= '0;
      error_q   <= 1'b0;
    end else if (ce) begin
      push_q  <= 1'b0;
      error_q <= 1'b0;
      if (state_q == ST_IDLE || fall_q) tmo_q <= '0;
      else                              tmo_q <= tmo_q + 1'b1;

      if (state_q != ST_IDLE && !fall_q && tmo_q == TW'(TIMEOUT - 1)) begin
        state_q <= ST_IDLE;
        error_q <= 1'b1;
        ext_q   <= 1'b0;
        rel_q   <= 1'b0;
        tmo_q   <= '0;
      end else if (fall_q) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!bit_q) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            shift_q   <= {bit_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_q <= bit_q;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (!frame_ok(shift_q, parity_q, bit_q)) begin
              error_q <= 1'b1;
            end else if (shift_q == PS2_PREFIX_EXT) begin
              ext_q <= 1'b1;
            end else if (shift_q == PS2_PREFIX_BRK) begin
              rel_q <= 1'b1;
            end else begin
              push_q    <= 1'b1;
              push_ev_q <= '{extended: ext_q, released: rel_q, code: shift_q};
              ext_q     <= 1'b0;
              rel_q     <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Consumer handshake: valid holds the head event steady until a ce tick with
  // ack=1 pops it; ack while valid=0 has no effect.
  ps2_event_t head;
  logic       q_full;
  logic       q_empty;

  ps2_fifo #(
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk_i      (clock),
    .rst_ni     (reset),
    .ce_i       (ce),
    .push_i     (push_q),
    .data_i     (push_ev_q),
    .pop_i      (ack),
    .data_o     (head),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .overflow_o (overflow)
  );

  assign valid     = ~q_empty;
  assign code      = head.code;
  assign extended  = head.extended;
  assign released  = head.released;
  assign error     = error_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: drives PS/2 frames bit by bit and checks
// decoded events against a scoreboard queue. Honours PS2_FIFO_EN for depth.
module tb_ps2_receiver;

`ifdef PS2_FIFO_EN
  localparam int QDEPTH = 8;
`else
  localparam int QDEPTH = 1;
`endif
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce    = 1'b0;
  logic       ack   = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [1:0] ps2;
  logic       valid, extended, released, error, overflow;
  logic [7:0] code;
  logic [1:0] state_dbg;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         err_cnt  = 0;
  int         e0;
  logic       err_prev = 1'b0;
  logic       m_ext = 1'b0;
  logic       m_rel = 1'b0;
  logic       m_ovf = 1'b0;
  logic [9:0] exp_q[$];

  assign ps2 = {ps2_clk, ps2_dat};

  ps2_receiver dut (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .ps2       (ps2),
    .valid     (valid),
    .ack       (ack),
    .code      (code),
    .extended  (extended),
    .released  (released),
    .error     (error),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // clock / ce: one ce tick every two clocks
  always #5 clock = ~clock;
  always @(posedge clock) ce <= ~ce;

  always @(negedge clock) begin
    if (error && !err_prev) err_cnt++;
    err_prev = error;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (2 * n) @(negedge clock);
  endtask

  task automatic send_bit(input logic v, input bit glitch);
    ps2_dat = v;
    if (glitch) begin
      wait_ticks(12);
      ps2_clk = 1'b0;
      wait_ticks(1);
      ps2_clk = 1'b1;
      wait_ticks(HALF - 13);
    end else begin
      wait_ticks(HALF);
    end
    ps2_clk = 1'b0;
    wait_ticks(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop,
                            input int glitch_at);
    send_bit(1'b0, glitch_at == 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_at == i + 1);
    send_bit((~^b) ^ par_flip, glitch_at == 9);
    send_bit(stop, glitch_at == 10);
    ps2_dat = 1'b1;
    wait_ticks(HALF);
  endtask

  // Reference behaviour of prefix folding and queue capacity.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      if (exp_q.size() < QDEPTH) exp_q.push_back({m_ext, m_rel, b});
      else m_ovf = 1'b1;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic good_frame(input logic [7:0] b, input int glitch_at);
    send_frame(b, 1'b0, 1'b1, glitch_at);
    model_byte(b);
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
    check({tag, "_valid"}, valid, 1);
    check(tag, {extended, released, code}, e);
    ack = 1'b1;
    wait_ticks(1);
    ack = 1'b0;
    wait_ticks(1);
  endtask

  initial begin
    reset = 1'b0;
    wait_ticks(4);
    check("rst_valid", valid, 0);
    check("rst_code", code, 0);
    check("rst_ext", extended, 0);
    check("rst_rel", released, 0);
    check("rst_error", error, 0);
    check("rst_ovf", overflow, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b1;
    wait_ticks(4);

    ack = 1'b1;
    wait_ticks(1);
    ack = 1'b0;
    check("ack_empty", valid, 0);

    good_frame(8'h1C, -1);
    check("err_1c", err_cnt, 0);
    pop_check("ev_1c");
    check("popped_1c", valid, 0);

    good_frame(8'hE0, -1);
    check("noev_e0", valid, 0);
    good_frame(8'hF0, -1);
    check("noev_f0", valid, 0);
    good_frame(8'h75, -1);
    pop_check("ev_e0f075");
    check("single_75", valid, 0);
    good_frame(8'h5A, -1);
    pop_check("ev_flags_clr");
    good_frame(8'hE0, -1);
    good_frame(8'h6B, -1);
    pop_check("ev_e06b");

    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    check("par_err", err_cnt, e0 + 1);
    check("par_noev", valid, 0);
    good_frame(8'h32, -1);
    pop_check("ev_32");

    e0 = err_cnt;
    send_frame(8'h44, 1'b0, 1'b0, -1);
    check("stop_err", err_cnt, e0 + 1);
    check("stop_noev", valid, 0);

    // prefix pending, then a frame that stalls after four data bits
    good_frame(8'hE0, -1);
    e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_dat = 1'b1;
    wait_ticks(660);
    check("tmo_early", err_cnt, e0);
    wait_ticks(60);
    check("tmo_err", err_cnt, e0 + 1);
    check("tmo_idle", state_dbg, 0);
    m_ext = 1'b0;
    m_rel = 1'b0;
    wait_ticks(80);
    good_frame(8'h1B, -1);
    pop_check("ev_1b");

    e0 = err_cnt;
    ps2_clk = 1'b0;
    wait_ticks(1);
    ps2_clk = 1'b1;
    wait_ticks(HALF);
    check("glitch_idle", state_dbg, 0);
    good_frame(8'h29, 3);
    check("glitch_noerr", err_cnt, e0);
    pop_check("ev_29");

    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    reset = 1'b0;
    wait_ticks(2);
    check("midrst_state", state_dbg, 0);
    check("midrst_valid", valid, 0);
    reset = 1'b1;
    ps2_dat = 1'b1;
    wait_ticks(HALF);
    good_frame(8'h4D, -1);
    pop_check("ev_4d");

    check("ovf_clear", overflow, 0);
    for (int i = 1; i <= QDEPTH + 1; i++) good_frame(8'(i), -1);
    check("ovf_set", overflow, m_ovf);
    for (int i = 0; i < QDEPTH; i++) pop_check($sformatf("ovf_pop%0d", i));
    check("ovf_drained", valid, 0);
    check("ovf_sticky", overflow, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
